// File: rtl/plab3_mem_l2reqarbiter.sv
// Two-port request arbiter in front of a blocking L2 cache.
// One transaction is in flight end to end. Request and response are each
// registered once. The message bits are passed through untouched.
module plab3_mem_l2reqarbiter #(
   parameter int unsigned p_opaque_nbits = 8,
   parameter int unsigned p_addr_nbits   = 32,
   parameter int unsigned p_data_nbits   = 128,
   localparam int unsigned LenNbits  = $clog2(p_data_nbits / 8),
   localparam int unsigned ReqNbits  = 3 + p_opaque_nbits + p_addr_nbits + LenNbits
                                       + p_data_nbits,
   localparam int unsigned RespNbits = 3 + p_opaque_nbits + 2 + LenNbits + p_data_nbits
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic [ReqNbits-1:0]  in0_req_msg,
   input  logic                 in0_req_val,
   output logic                 in0_req_rdy,
   output logic [RespNbits-1:0] in0_resp_msg,
   output logic                 in0_resp_val,
   input  logic                 in0_resp_rdy,

   input  logic [ReqNbits-1:0]  in1_req_msg,
   input  logic                 in1_req_val,
   output logic                 in1_req_rdy,
   output logic [RespNbits-1:0] in1_resp_msg,
   output logic                 in1_resp_val,
   input  logic                 in1_resp_rdy,

   output logic [ReqNbits-1:0]  out_req_msg,
   output logic                 out_req_val,
   input  logic                 out_req_rdy,
   input  logic [RespNbits-1:0] out_resp_msg,
   input  logic                 out_resp_val,
   output logic                 out_resp_rdy,

   output logic                 grant_id
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StSend = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   logic [1:0]           state_q,    state_d;
   logic                 rr_ptr_q,   rr_ptr_d;
   logic                 grant_q,    grant_d;
   logic [ReqNbits-1:0]  req_buf_q,  req_buf_d;
   logic [RespNbits-1:0] resp_buf_q, resp_buf_d;

   logic any_val;
   logic winner;

   // Port chosen this cycle: round-robin pointer breaks ties, otherwise the lone valid port.
   always_comb begin
      any_val = in0_req_val | in1_req_val;
      if (in0_req_val && in1_req_val) begin
         winner = rr_ptr_q;
      end else begin
         winner = in1_req_val;
      end
   end

   // Next-state and handshake outputs for the four-phase transaction.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      req_buf_d    = req_buf_q;
      resp_buf_d   = resp_buf_q;
      in0_req_rdy  = 1'b0;
      in1_req_rdy  = 1'b0;
      out_req_val  = 1'b0;
      out_resp_rdy = 1'b0;
      in0_resp_val = 1'b0;
      in1_resp_val = 1'b0;

      case (state_q)
         StIdle: begin
            if (any_val) begin
               in0_req_rdy = ~winner;
               in1_req_rdy = winner;
               req_buf_d   = winner ? in1_req_msg : in0_req_msg;
               grant_d     = winner;
               rr_ptr_d    = ~winner;
               state_d     = StSend;
            end
         end
         StSend: begin
            out_req_val = 1'b1;
            if (out_req_rdy) begin
               state_d = StWait;
            end
         end
         StWait: begin
            out_resp_rdy = 1'b1;
            if (out_resp_val) begin
               resp_buf_d = out_resp_msg;
               state_d    = StResp;
            end
         end
         StResp: begin
            in0_resp_val = ~grant_q;
            in1_resp_val = grant_q;
            // Return to idle only; a new request is taken on the following cycle.
            if (grant_q ? in1_resp_rdy : in0_resp_rdy) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Response data is broadcast; only the valid is steered to the requester.
   always_comb begin
      in0_resp_msg = resp_buf_q;
      in1_resp_msg = resp_buf_q;
      out_req_msg  = req_buf_q;
      grant_id     = grant_q;
   end

   // State and buffers; reset drops any in-flight transaction immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= 1'b0;
         grant_q    <= 1'b0;
         req_buf_q  <= '0;
         resp_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         req_buf_q  <= req_buf_d;
         resp_buf_q <= resp_buf_d;
      end
   end

endmodule

// File: tb/tb_plab3_mem_l2reqarbiter.sv
// Self-checking bench for the two-port L2 request arbiter.
`timescale 1ns/1ps
module tb_plab3_mem_l2reqarbiter;

   localparam int REQ_W  = 3 + 8 + 32 + 4 + 128;
   localparam int RESP_W = 3 + 8 + 2 + 4 + 128;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [REQ_W-1:0]  in0_req_msg, in1_req_msg, out_req_msg;
   logic              in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
   logic [RESP_W-1:0] in0_resp_msg, in1_resp_msg, out_resp_msg;
   logic              in0_resp_val, in0_resp_rdy, in1_resp_val, in1_resp_rdy;
   logic              out_req_val, out_req_rdy, out_resp_val, out_resp_rdy;
   logic              grant_id;

   int total = 0;
   int bad   = 0;

   plab3_mem_l2reqarbiter dut (
      .clk          (clk),
      .reset        (reset),
      .in0_req_msg  (in0_req_msg),
      .in0_req_val  (in0_req_val),
      .in0_req_rdy  (in0_req_rdy),
      .in0_resp_msg (in0_resp_msg),
      .in0_resp_val (in0_resp_val),
      .in0_resp_rdy (in0_resp_rdy),
      .in1_req_msg  (in1_req_msg),
      .in1_req_val  (in1_req_val),
      .in1_req_rdy  (in1_req_rdy),
      .in1_resp_msg (in1_resp_msg),
      .in1_resp_val (in1_resp_val),
      .in1_resp_rdy (in1_resp_rdy),
      .out_req_msg  (out_req_msg),
      .out_req_val  (out_req_val),
      .out_req_rdy  (out_req_rdy),
      .out_resp_msg (out_resp_msg),
      .out_resp_val (out_resp_val),
      .out_resp_rdy (out_resp_rdy),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   // Request layout: {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
   function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] opq,
                                               input logic [31:0] addr, input logic [3:0] len,
                                               input logic [127:0] data);
      return {t, opq, addr, len, data};
   endfunction

   function automatic logic [REQ_W-1:0] rand_req(input int port, input int serial);
      logic [2:0] t;
      logic [3:0] len;
      t   = 3'($urandom_range(0, 1));
      len = 4'($urandom_range(0, 15));
      return {t, serial[7:0], (port != 0 ? 16'h2000 : 16'h1000), serial[15:0], len,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   // L2 model: echo type/opaque/len, test=01, data scrambled with the address.
   function automatic logic [RESP_W-1:0] l2_resp(input logic [REQ_W-1:0] r);
      return {r[174:172], r[171:164], 2'b01, r[131:128], r[127:0] ^ {4{r[163:132]}}};
   endfunction

   task automatic drive_idle();
      in0_req_val = 1'b0; in0_req_msg = '0; in0_resp_rdy = 1'b0;
      in1_req_val = 1'b0; in1_req_msg = '0; in1_resp_rdy = 1'b0;
      out_req_rdy = 1'b0; out_resp_val = 1'b0; out_resp_msg = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      repeat (3) @(negedge clk);
      total++;
      if ({in0_req_rdy, in1_req_rdy, in0_resp_val, in1_resp_val, out_req_val, out_resp_rdy}
          !== 6'b0) begin
         bad++;
         $display("FAIL reset_valrdy: got %b want 000000", {in0_req_rdy, in1_req_rdy,
                  in0_resp_val, in1_resp_val, out_req_val, out_resp_rdy});
      end
      total++;
      if (grant_id !== 1'b0) begin
         bad++; $display("FAIL reset_grant: got %b want 0", grant_id);
      end
      total++;
      if (out_req_msg !== '0) begin
         bad++; $display("FAIL reset_reqbuf: got %h want 0", out_req_msg);
      end
      total++;
      if (in0_resp_msg !== '0 || in1_resp_msg !== '0) begin
         bad++; $display("FAIL reset_respbuf: got %h/%h want 0", in0_resp_msg, in1_resp_msg);
      end
      reset = 1'b0;
   endtask

   task automatic test_port0_only();
      logic [REQ_W-1:0]  r;
      logic [RESP_W-1:0] rs;
      r  = mk_req(3'd0, 8'h05, 32'h0000_1000, 4'd0, 128'd0);
      rs = {3'd0, 8'h05, 2'b00, 4'd0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF};
      @(negedge clk);
      in0_req_val = 1'b1; in0_req_msg = r;
      #1;
      total++;
      if ({in1_req_rdy, in0_req_rdy} !== 2'b01) begin
         bad++; $display("FAIL p0_rdy: got %b want 01", {in1_req_rdy, in0_req_rdy});
      end
      @(negedge clk);
      in0_req_val = 1'b0;
      total++;
      if (out_req_val !== 1'b1 || out_req_msg !== r) begin
         bad++; $display("FAIL p0_outreq: got val=%b msg=%h want val=1 msg=%h",
                         out_req_val, out_req_msg, r);
      end
      total++;
      if (grant_id !== 1'b0) begin
         bad++; $display("FAIL p0_grant: got %b want 0", grant_id);
      end
      out_req_rdy = 1'b1;
      @(negedge clk);
      out_req_rdy = 1'b0;
      total++;
      if (out_resp_rdy !== 1'b1 || out_req_val !== 1'b0) begin
         bad++; $display("FAIL p0_wait: got resp_rdy=%b req_val=%b want 1 0",
                         out_resp_rdy, out_req_val);
      end
      out_resp_val = 1'b1; out_resp_msg = rs;
      @(negedge clk);
      out_resp_val = 1'b0;
      total++;
      if ({in1_resp_val, in0_resp_val} !== 2'b01) begin
         bad++; $display("FAIL p0_respval: got %b want 01", {in1_resp_val, in0_resp_val});
      end
      total++;
      if (in0_resp_msg !== rs) begin
         bad++; $display("FAIL p0_respmsg: got %h want %h", in0_resp_msg, rs);
      end
      in0_resp_rdy = 1'b1;
      @(negedge clk);
      in0_resp_rdy = 1'b0;
      total++;
      if ({in1_resp_val, in0_resp_val, out_req_val} !== 3'b000) begin
         bad++; $display("FAIL p0_done: got %b want 000", {in1_resp_val, in0_resp_val, out_req_val});
      end
   endtask

   task automatic test_fairness();
      logic [REQ_W-1:0] q0 [6];
      logic [REQ_W-1:0] q1 [6];
      logic [REQ_W-1:0] cur;
      int i0, i1, ngrant, nresp, cur_p, p;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         q0[k] = rand_req(0, 16 + k);
         q1[k] = rand_req(1, 32 + k);
      end
      i0 = 0; i1 = 0; ngrant = 0; nresp = 0; cur_p = -1; cur = '0;
      out_req_rdy = 1'b1; in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
      for (int cyc = 0; cyc < 300 && nresp < 12; cyc++) begin
         @(negedge clk);
         in0_req_val  = (i0 < 6);
         in0_req_msg  = q0[(i0 < 6) ? i0 : 5];
         in1_req_val  = (i1 < 6);
         in1_req_msg  = q1[(i1 < 6) ? i1 : 5];
         out_resp_val = (cur_p >= 0);
         out_resp_msg = l2_resp(cur);
         #1;
         if (in0_resp_val || in1_resp_val) begin
            total++;
            if ({in1_resp_val, in0_resp_val} !== (cur_p == 1 ? 2'b10 : 2'b01)) begin
               bad++; $display("FAIL fair_steer: got %b for port %0d",
                               {in1_resp_val, in0_resp_val}, cur_p);
            end
            total++;
            if (in0_resp_msg !== l2_resp(cur)) begin
               bad++; $display("FAIL fair_respmsg: got %h want %h", in0_resp_msg, l2_resp(cur));
            end
            nresp++;
         end
         if (out_req_val) begin
            total++;
            if (out_req_msg !== cur) begin
               bad++; $display("FAIL fair_outreq: got %h want %h", out_req_msg, cur);
            end
         end
         if ((in0_req_val && in0_req_rdy) || (in1_req_val && in1_req_rdy)) begin
            p = (in1_req_val && in1_req_rdy) ? 1 : 0;
            total++;
            if (p != ngrant % 2 || (in0_req_rdy && in1_req_rdy)) begin
               bad++; $display("FAIL fair_order: grant %0d got port %0d want %0d (rdy %b%b)",
                               ngrant, p, ngrant % 2, in1_req_rdy, in0_req_rdy);
            end
            cur   = (p == 1) ? q1[i1] : q0[i0];
            cur_p = p;
            if (p == 1) i1++; else i0++;
            ngrant++;
         end
      end
      total++;
      if (nresp != 12) begin
         bad++; $display("FAIL fair_count: got %0d responses want 12", nresp);
      end
      drive_idle();
   endtask

   task automatic test_send_stall();
      logic [REQ_W-1:0] r;
      do_reset();
      r = rand_req(0, 77);
      @(negedge clk);
      in0_req_val = 1'b1; in0_req_msg = r;
      @(negedge clk);
      in0_req_msg = rand_req(0, 78);
      in1_req_val = 1'b1; in1_req_msg = rand_req(1, 79);
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (out_req_val !== 1'b1 || out_req_msg !== r) begin
            bad++; $display("FAIL stall_hold: cyc %0d got val=%b msg=%h want msg=%h",
                            k, out_req_val, out_req_msg, r);
         end
         total++;
         if ({in1_req_rdy, in0_req_rdy} !== 2'b00) begin
            bad++; $display("FAIL stall_inrdy: cyc %0d got %b want 00", k,
                            {in1_req_rdy, in0_req_rdy});
         end
         @(negedge clk);
      end
      out_req_rdy = 1'b1;
      @(negedge clk);
      out_req_rdy = 1'b0;
      total++;
      if (out_resp_rdy !== 1'b1 || out_req_val !== 1'b0) begin
         bad++; $display("FAIL stall_wait: got resp_rdy=%b req_val=%b want 1 0",
                         out_resp_rdy, out_req_val);
      end
      drive_idle();
   endtask

   task automatic test_resp_stall();
      logic [REQ_W-1:0]  r, r0;
      logic [RESP_W-1:0] rs;
      do_reset();
      r  = rand_req(1, 90);
      r0 = rand_req(0, 91);
      rs = l2_resp(r);
      @(negedge clk);
      in1_req_val = 1'b1; in1_req_msg = r;
      @(negedge clk);
      in1_req_val = 1'b0; out_req_rdy = 1'b1;
      @(negedge clk);
      out_req_rdy = 1'b0; out_resp_val = 1'b1; out_resp_msg = rs;
      @(negedge clk);
      out_resp_val = 1'b0; out_resp_msg = '0;
      in0_req_val = 1'b1; in0_req_msg = r0;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++;
         if ({in1_resp_val, in0_resp_val} !== 2'b10 || in1_resp_msg !== rs) begin
            bad++; $display("FAIL rstall_hold: cyc %0d got val=%b msg=%h want 10 %h", k,
                            {in1_resp_val, in0_resp_val}, in1_resp_msg, rs);
         end
         total++;
         if (in0_req_rdy !== 1'b0) begin
            bad++; $display("FAIL rstall_block: cyc %0d got in0_req_rdy=%b want 0", k, in0_req_rdy);
         end
         @(negedge clk);
      end
      in1_resp_rdy = 1'b1;
      #1;
      total++;
      if (in0_req_rdy !== 1'b0) begin
         bad++; $display("FAIL rstall_samecyc: got in0_req_rdy=%b want 0", in0_req_rdy);
      end
      @(negedge clk);
      in1_resp_rdy = 1'b0;
      #1;
      total++;
      if (in0_req_rdy !== 1'b1) begin
         bad++; $display("FAIL rstall_next: got in0_req_rdy=%b want 1", in0_req_rdy);
      end
      @(negedge clk);
      in0_req_val = 1'b0;
      total++;
      if (out_req_val !== 1'b1 || out_req_msg !== r0 || grant_id !== 1'b0) begin
         bad++; $display("FAIL rstall_newreq: got val=%b grant=%b msg=%h want 1 0 %h",
                         out_req_val, grant_id, out_req_msg, r0);
      end
      drive_idle();
   endtask

   task automatic test_reset_midflight();
      logic [REQ_W-1:0] r0, r1;
      do_reset();
      r0 = rand_req(0, 100);
      r1 = rand_req(1, 101);
      @(negedge clk);
      in0_req_val = 1'b1; in0_req_msg = r0;
      @(negedge clk);
      in0_req_val = 1'b0; out_req_rdy = 1'b1;
      @(negedge clk);
      out_req_rdy = 1'b0;
      total++;
      if (out_resp_rdy !== 1'b1) begin
         bad++; $display("FAIL rmid_inwait: got out_resp_rdy=%b want 1", out_resp_rdy);
      end
      out_resp_val = 1'b1; out_resp_msg = l2_resp(r0);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({in0_req_rdy, in1_req_rdy, in0_resp_val, in1_resp_val, out_req_val, out_resp_rdy}
          !== 6'b0 || grant_id !== 1'b0) begin
         bad++; $display("FAIL rmid_async: got %b grant=%b want 000000 0", {in0_req_rdy,
                         in1_req_rdy, in0_resp_val, in1_resp_val, out_req_val, out_resp_rdy},
                         grant_id);
      end
      @(negedge clk);
      reset = 1'b0; out_resp_val = 1'b0;
      in0_req_val = 1'b1; in0_req_msg = r0;
      in1_req_val = 1'b1; in1_req_msg = r1;
      #1;
      total++;
      if ({in1_req_rdy, in0_req_rdy} !== 2'b01) begin
         bad++; $display("FAIL rmid_rrptr: got %b want 01", {in1_req_rdy, in0_req_rdy});
      end
      in0_req_val = 1'b0;
      #1;
      total++;
      if ({in1_req_rdy, in0_req_rdy} !== 2'b10) begin
         bad++; $display("FAIL rmid_in1rdy: got %b want 10", {in1_req_rdy, in0_req_rdy});
      end
      @(negedge clk);
      in1_req_val = 1'b0;
      total++;
      if (grant_id !== 1'b1 || out_req_val !== 1'b1 || out_req_msg !== r1) begin
         bad++; $display("FAIL rmid_grant1: got grant=%b val=%b msg=%h want 1 1 %h",
                         grant_id, out_req_val, out_req_msg, r1);
      end
      drive_idle();
   endtask

   // Randomised traffic against a transaction-level model:
   // phase 0 free, 1 accepted/not yet at L2, 2 at L2, 3 response pending upstream.
   task automatic test_random();
      logic [REQ_W-1:0] head0, head1, cur, l2q [$];
      logic [1:0] exp_rdy, exp_rval;
      int done, phase, org, rr, serial, cyc, w;
      do_reset();
      done = 0; phase = 0; org = 0; rr = 0; serial = 200; cyc = 0; cur = '0;
      head0 = rand_req(0, serial); serial++;
      head1 = rand_req(1, serial); serial++;
      while (done < 1000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         in0_req_val  = 1'($urandom_range(0, 1)); in0_req_msg = head0;
         in1_req_val  = 1'($urandom_range(0, 1)); in1_req_msg = head1;
         out_req_rdy  = 1'($urandom_range(0, 1));
         out_resp_val = 1'($urandom_range(0, 1));
         out_resp_msg = (l2q.size() > 0) ? l2_resp(l2q[0]) : RESP_W'({$urandom, $urandom});
         in0_resp_rdy = 1'($urandom_range(0, 1));
         in1_resp_rdy = 1'($urandom_range(0, 1));
         #1;
         w = (in0_req_val && in1_req_val) ? rr : (in1_req_val ? 1 : 0);
         exp_rdy  = (phase == 0 && (in0_req_val || in1_req_val)) ? (w == 1 ? 2'b10 : 2'b01)
                                                                 : 2'b00;
         exp_rval = (phase == 3) ? (org == 1 ? 2'b10 : 2'b01) : 2'b00;
         total++;
         if ({in1_req_rdy, in0_req_rdy} !== exp_rdy) begin
            bad++; $display("FAIL rnd_reqrdy: cyc %0d got %b want %b", cyc,
                            {in1_req_rdy, in0_req_rdy}, exp_rdy);
         end
         total++;
         if ({in1_resp_val, in0_resp_val} !== exp_rval) begin
            bad++; $display("FAIL rnd_respval: cyc %0d got %b want %b", cyc,
                            {in1_resp_val, in0_resp_val}, exp_rval);
         end
         total++;
         if (out_req_val !== (phase == 1) || out_resp_rdy !== (phase == 2)) begin
            bad++; $display("FAIL rnd_l2side: cyc %0d got req_val=%b resp_rdy=%b phase %0d",
                            cyc, out_req_val, out_resp_rdy, phase);
         end
         case (phase)
            0: if (in0_req_val || in1_req_val) begin
               cur = (w == 1) ? head1 : head0;
               org = w; rr = 1 - w; phase = 1;
               if (w == 1) head1 = rand_req(1, serial); else head0 = rand_req(0, serial);
               serial++;
            end
            1: if (out_req_rdy) begin
               total++;
               if (out_req_msg !== cur) begin
                  bad++; $display("FAIL rnd_outmsg: got %h want %h", out_req_msg, cur);
               end
               l2q.push_back(cur);
               phase = 2;
            end
            2: if (out_resp_val) begin
               void'(l2q.pop_front());
               phase = 3;
            end
            default: if (org == 1 ? in1_resp_rdy : in0_resp_rdy) begin
               total++;
               if (in0_resp_msg !== l2_resp(cur) || in1_resp_msg !== l2_resp(cur)) begin
                  bad++; $display("FAIL rnd_respmsg: got %h/%h want %h", in0_resp_msg,
                                  in1_resp_msg, l2_resp(cur));
               end
               done++;
               phase = 0;
            end
         endcase
      end
      total++;
      if (done != 1000) begin
         bad++; $display("FAIL rnd_count: got %0d transactions want 1000 in %0d cycles", done, cyc);
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_port0_only();
      test_fairness();
      test_send_stall();
      test_resp_stall();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
